// File: rtl/vga_sync_pkg.sv
// Shared timing constants and coordinate type for the video timing generator
// and every drawing layer that consumes its signed spot coordinates.
package vga_pkg;

  typedef logic signed [10:0] coord_t;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 56;
  localparam int H_SYNC   = 120;
  localparam int H_BP     = 64;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 37;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 23;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [7:0] BORDER_LEVEL = 8'd255;

  // Inclusive signed window test used for the sync pulse decodes.
  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Bundle between the timing generator (master) and the drawing layers / VGA
// connector side (slave).
interface vga_sync_if;
  import vga_pkg::*;

  coord_t     spotX;
  coord_t     spotY;
  logic       new_frame;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank;

  modport master (
    output spotX, spotY, new_frame,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  spotX, spotY, new_frame,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank,
    output pix_r, pix_g, pix_b
  );

endinterface

// File: rtl/vga_sync_counter.sv
// Signed wrap counter: counts MIN..MAX while enabled and flags the wrapping
// cycle so a following counter can chain off it.
import vga_pkg::*;

module sync_counter #(
  parameter coord_t MIN = -11'sd240,
  parameter coord_t MAX = 11'sd799
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   wrap
);

  coord_t count_r;

  assign wrap  = en && (count_r == MAX);
  assign count = count_r;

  // Count register: restart at MIN on reset or after reaching MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= MIN;
    end else if (wrap) begin
      count_r <= MIN;
    end else if (en) begin
      count_r <= count_r + 11'sd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// 800x600@72 timing generator with signed spot coordinates and a one-cycle
// aligned pixel stage. Optional macro VGA_BORDER_EN forces a white border.
import vga_pkg::*;

module vga_sync #(
  parameter int HACTIVE = H_ACTIVE,
  parameter int HFP     = H_FP,
  parameter int HSYNC   = H_SYNC,
  parameter int HBP     = H_BP,
  parameter int VACTIVE = V_ACTIVE,
  parameter int VFP     = V_FP,
  parameter int VSYNC   = V_SYNC,
  parameter int VBP     = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  vga_sync_if.master bus
);

  localparam coord_t X_MIN = coord_t'(-(HFP + HSYNC + HBP));
  localparam coord_t X_MAX = coord_t'(HACTIVE - 1);
  localparam coord_t Y_MIN = coord_t'(-(VFP + VSYNC + VBP));
  localparam coord_t Y_MAX = coord_t'(VACTIVE - 1);
  localparam coord_t HS_LO = coord_t'(-(HSYNC + HBP));
  localparam coord_t HS_HI = coord_t'(-HBP - 1);
  localparam coord_t VS_LO = coord_t'(-(VSYNC + VBP));
  localparam coord_t VS_HI = coord_t'(-VBP - 1);

  coord_t     x_s;
  coord_t     y_s;
  logic       hwrap_s;
  logic       vwrap_s;
  logic       run_r;
  logic       new_frame_r;
  logic       active_s;
  logic       hs_s;
  logic       vs_s;
  logic [7:0] r_s;
  logic [7:0] g_s;
  logic [7:0] b_s;
  logic [7:0] r_r;
  logic [7:0] g_r;
  logic [7:0] b_r;
  logic       hs_r;
  logic       vs_r;
  logic       blank_r;

  // The first cycle after reset sits on the frame-start spot, so counting is held one edge.
  sync_counter #(.MIN(X_MIN), .MAX(X_MAX)) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (run_r),
    .count (x_s),
    .wrap  (hwrap_s)
  );

  sync_counter #(.MIN(Y_MIN), .MAX(Y_MAX)) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hwrap_s),
    .count (y_s),
    .wrap  (vwrap_s)
  );

  // Run flag and frame pulse: pulse whenever the next spot is the frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r       <= 1'b0;
      new_frame_r <= 1'b0;
    end else begin
      run_r       <= 1'b1;
      new_frame_r <= (~run_r) | vwrap_s;
    end
  end

  // Pixel stage decode for the current spot.
  always_comb begin
    active_s = (x_s >= 11'sd0) && (y_s >= 11'sd0);
    hs_s     = in_range(x_s, HS_LO, HS_HI);
    vs_s     = in_range(y_s, VS_LO, VS_HI);
    r_s      = 8'd0;
    g_s      = 8'd0;
    b_s      = 8'd0;
    if (active_s) begin
      r_s = bus.pix_r;
      g_s = bus.pix_g;
      b_s = bus.pix_b;
`ifdef VGA_BORDER_EN
      if ((x_s == 11'sd0) || (x_s == X_MAX) || (y_s == 11'sd0) || (y_s == Y_MAX)) begin
        r_s = BORDER_LEVEL;
        g_s = BORDER_LEVEL;
        b_s = BORDER_LEVEL;
      end else begin
        r_s = bus.pix_r;
        g_s = bus.pix_g;
        b_s = bus.pix_b;
      end
`endif
    end else begin
      r_s = 8'd0;
      g_s = 8'd0;
      b_s = 8'd0;
    end
  end

  // Pixel stage register keeps colour and syncs aligned one cycle behind the spot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r     <= 8'd0;
      g_r     <= 8'd0;
      b_r     <= 8'd0;
      hs_r    <= 1'b0;
      vs_r    <= 1'b0;
      blank_r <= 1'b1;
    end else begin
      r_r     <= r_s;
      g_r     <= g_s;
      b_r     <= b_s;
      hs_r    <= hs_s;
      vs_r    <= vs_s;
      blank_r <= ~active_s;
    end
  end

  assign bus.spotX     = x_s;
  assign bus.spotY     = y_s;
  assign bus.new_frame = new_frame_r;
  assign bus.vga_r     = r_r;
  assign bus.vga_g     = g_r;
  assign bus.vga_b     = b_r;
  assign bus.vga_hs    = hs_r;
  assign bus.vga_vs    = vs_r;
  assign bus.vga_blank = blank_r;

endmodule
